// File: rtl/force_accumulator.sv
// force_accumulator: per-particle FP32 force accumulator with a valid/ready drain stream
module fp32_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y
);
  logic [31:0] bb, x, z, r;
  logic [7:0]  ex, ez, d;
  logic [26:0] mx, mz, mz_sh, n;
  logic [27:0] sum;
  logic [4:0]  lz, sh;
  logic [8:0]  e;
  logic [24:0] mant;
  logic        eff_sub, a_nan, b_nan, a_inf, b_inf, inc;
  // Align the smaller operand, add or subtract with guard/round/sticky, normalise, round to nearest even
  always_comb begin
    bb = {b[31] ^ sub, b[30:0]};
    x = (bb[30:0] > a[30:0]) ? bb : a;
    z = (bb[30:0] > a[30:0]) ? a : bb;
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ez = (z[30:23] == 8'd0) ? 8'd1 : z[30:23];
    mx = {|x[30:23], x[22:0], 3'b000};
    mz = {|z[30:23], z[22:0], 3'b000};
    d = ex - ez;
    mz_sh = (d >= 8'd27) ? {26'd0, |mz} : ((mz >> d) | {26'd0, |(mz & ~({27{1'b1}} << d))});
    eff_sub = x[31] ^ z[31];
    sum = eff_sub ? ({1'b0, mx} - {1'b0, mz_sh}) : ({1'b0, mx} + {1'b0, mz_sh});
    lz = 5'd26;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    sh = (9'(lz) < 9'(ex)) ? lz : 5'(ex - 8'd1);
    n = sum[27] ? {sum[27:2], sum[1] | sum[0]} : (sum[26:0] << sh);
    e = sum[27] ? (9'(ex) + 9'd1) : (9'(ex) - 9'(sh));
    inc = n[2] & (n[3] | n[1] | n[0]);
    mant = {1'b0, n[26:3]} + 25'(inc);
    r = ((32'(e) - 32'd1) << 23) + 32'(mant);
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);
    y = a_nan ? (a | 32'h0040_0000) :
        b_nan ? (b | 32'h0040_0000) :
        (a_inf & b_inf & (a[31] ^ bb[31])) ? 32'h7FC0_0000 :
        a_inf ? a :
        b_inf ? bb :
        (sum == 28'd0) ? {x[31] & z[31], 31'd0} :
        (r[31] | (&r[30:23])) ? {x[31], 8'hFF, 23'd0} : {x[31], r[30:0]};
  end
endmodule

module force_accumulator #(
  parameter int N_PART = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_sub,
  input  logic [31:0]      in_fx,
  input  logic [31:0]      in_fy,
  input  logic [31:0]      in_fz,
  input  logic             start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [31:0]      out_fx,
  output logic [31:0]      out_fy,
  output logic [31:0]      out_fz,
  output logic             done,
  output logic             idx_err
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t           state;
  logic [IDX_W-1:0] ptr, widx;
  logic [31:0]      acc_x [N_PART];
  logic [31:0]      acc_y [N_PART];
  logic [31:0]      acc_z [N_PART];
  logic [31:0]      sum_x, sum_y, sum_z;
  logic             in_range;
  assign in_range  = {1'b0, in_idx} < (IDX_W + 1)'(N_PART);
  assign widx      = in_range ? in_idx : '0;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DRAIN;
  assign out_idx   = ptr;
  assign out_fx    = acc_x[ptr];
  assign out_fy    = acc_y[ptr];
  assign out_fz    = acc_z[ptr];
  fp32_add u_add_x (.a(acc_x[widx]), .b(in_fx), .sub(in_sub), .y(sum_x));
  fp32_add u_add_y (.a(acc_y[widx]), .b(in_fy), .sub(in_sub), .y(sum_y));
  fp32_add u_add_z (.a(acc_z[widx]), .b(in_fz), .sub(in_sub), .y(sum_z));
  // Accumulate contributions while idle; on start walk the file, clearing each slot as it is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      done    <= 1'b0;
      idx_err <= 1'b0;
      for (int i = 0; i < N_PART; i++) begin
        acc_x[i] <= 32'd0;
        acc_y[i] <= 32'd0;
        acc_z[i] <= 32'd0;
      end
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (in_valid && in_range) begin
          acc_x[in_idx] <= sum_x;
          acc_y[in_idx] <= sum_y;
          acc_z[in_idx] <= sum_z;
        end
        if (in_valid && !in_range) idx_err <= 1'b1;
        if (start) begin
          state <= DRAIN;
          ptr   <= '0;
        end
      end else if (out_ready) begin
        acc_x[ptr] <= 32'd0;
        acc_y[ptr] <= 32'd0;
        acc_z[ptr] <= 32'd0;
        ptr        <= ptr + 1'b1;
        if (ptr == IDX_W'(N_PART - 1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end
endmodule
